ro_trng_collector: RTL

- Parametrised successor of the two-oscillator XOR sampler.
- Instantiates NUM_RO `ro` ring oscillators, each with a 2-flop synchroniser, and XORs the synchronised outputs into one raw entropy bit per clock.
- Adds optional von Neumann debiasing and a start/fill/ready capture FSM; the DEPTH-bit shift register freezes once full so the OUT_W-bit window readout is stable.
- Sits between the ring oscillators and the top-level output mux; readout is software/pin-selected via out_sel.

---
 rtl/ro_trng_collector.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ro_trng_collector.sv
// ro_trng_collector: ring-oscillator entropy collector.
//
// Purpose:
//   NUM_RO ring oscillators are each synchronised through two flops. The
//   synchronised outputs are XORed into one raw entropy bit per clock. Bits
//   are optionally von Neumann debiased, then captured into a DEPTH-bit shift
//   register under a start/fill/ready FSM. The register freezes once full, so
//   the OUT_W-bit window selected by out_sel reads back stable data.
//
// Ports:
//   clk         single clock, all flops on posedge
//   rst_n       synchronous active-low reset
//   ro_en       per-oscillator enable, bit i drives oscillator i
//   start       one-cycle pulse that begins (or restarts) a capture
//   debias      0 = raw XOR bits, 1 = von Neumann debiased bits
//   out_sel     window index k -> shift_reg[k*OUT_W +: OUT_W]
//   out         registered readout window (1-cycle latency)
//   ready       high in FULL (DEPTH new bits captured)
//   busy        high in FILL
//   fill_count  bits accepted in the current capture, saturates at DEPTH
//
// FSM visibility: {busy, ready} encode the state one-to-one
//   (IDLE = 00, FILL = 10, FULL = 01), both registered with the state.
//
// Handshake: start is a level sampled every clock; it is acted on in every
//   state, and a cycle with start high never accepts an entropy bit.

// Portable stand-in for the ring-oscillator macro. The silicon cell replaces
// this; it keeps the same contract: a disabled oscillator drives 0.
module ro (
  input  logic ro_activate,
  output logic ro_out
);
  assign ro_out = ro_activate;
endmodule

module ro_trng_collector #(
  parameter int NUM_RO = 2,
  parameter int DEPTH  = 64,
  parameter int OUT_W  = 8,
  parameter int SEL_W  = ((DEPTH / OUT_W) > 1) ? $clog2(DEPTH / OUT_W) : 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_RO-1:0] ro_en,
  input  logic              start,
  input  logic              debias,
  input  logic [SEL_W-1:0]  out_sel,
  output logic [OUT_W-1:0]  out,
  output logic              ready,
  output logic              busy,
  output logic [CNT_W-1:0]  fill_count
);

  localparam int NWIN = DEPTH / OUT_W;

  if (NUM_RO < 2 || NUM_RO > 8) begin : g_bad_num_ro
    $error("ro_trng_collector: NUM_RO must be in 2..8");
  end
  if ((DEPTH % OUT_W) != 0) begin : g_bad_depth
    $error("ro_trng_collector: DEPTH must be a multiple of OUT_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_RO-1:0]  ro_out;
  logic [NUM_RO-1:0]  s1;
  logic [NUM_RO-1:0]  s2;
  logic               raw_bit;
  logic               phase;
  logic               pair_first;
  logic               accept;
  logic               accept_bit;
  logic [DEPTH-1:0]   shift_reg;
  logic [OUT_W-1:0]   win;

  for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
    ro u_ro (
      .ro_activate (ro_en[i]),
      .ro_out      (ro_out[i])
    );
  end

  assign raw_bit = ^s2;

  // Raw mode takes every bit. Debiased mode decides on the second bit of a
  // pair: differing pairs emit the first bit, equal pairs are dropped.
  always_comb begin
    accept     = 1'b1;
    accept_bit = raw_bit;
    if (debias) begin
      accept     = phase && (pair_first != raw_bit);
      accept_bit = pair_first;
    end
  end

  // Window mux; an out_sel past the last window reads zero.
  always_comb begin
    win = '0;
    for (int k = 0; k < NWIN; k++) begin
      if (out_sel == SEL_W'(k)) win = shift_reg[k*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      pair_first <= 1'b0;
      phase      <= 1'b0;
      shift_reg  <= '0;
      fill_count <= '0;
      out        <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      state      <= IDLE;
    end else begin
      s1  <= ro_out;
      s2  <= s1;
      out <= win;
      case (state)
        IDLE, FULL: begin
          if (start) begin
            state      <= FILL;
            busy       <= 1'b1;
            ready      <= 1'b0;
            fill_count <= '0;
            phase      <= 1'b0;
          end
        end
        FILL: begin
          if (start) begin
            // Restart: old shift_reg contents are simply shifted out later.
            fill_count <= '0;
            phase      <= 1'b0;
          end else begin
            phase <= ~phase;
            if (!phase) pair_first <= raw_bit;
            if (accept) begin
              shift_reg  <= {shift_reg[DEPTH-2:0], accept_bit};
              fill_count <= fill_count + 1'b1;
              if (fill_count == CNT_W'(DEPTH - 1)) begin
                state <= FULL;
                busy  <= 1'b0;
                ready <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
